// File: rtl/intr_ctrl_if.sv
// CSR write port driven by the trap sequencer into the CSR register file.
// One full-register write per cycle while we is high.
interface intr_ctrl_if #(
    parameter int DW    = 32,
    parameter int ADDRW = 12
);
    logic             we;
    logic [ADDRW-1:0] addr;
    logic [DW-1:0]    wdata;

    modport master (output we, output addr, output wdata);
    modport slave  (input  we, input  addr, input  wdata);
endinterface

// File: rtl/intr_ctrl.sv
// Machine-mode trap sequencer: takes timer/external interrupts at an instruction
// boundary, saves mepc/mcause/mstatus one per cycle, and sequences MRET.
module intr_ctrl #(
    parameter int DW        = 32,
    parameter int ADDRW     = 12,
    parameter int MEI_CAUSE = 11,
    parameter int MTI_CAUSE = 7
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              t_intr_i,
    input  logic              e_intr_i,
    input  logic              is_mret_i,
    input  logic              commit_valid_i,
    input  logic [DW-1:0]     commit_pc_i,
    input  logic [DW-1:0]     mstatus_i,
    input  logic [DW-1:0]     mie_i,
    input  logic [DW-1:0]     mtvec_i,
    input  logic [DW-1:0]     mepc_i,
    intr_ctrl_if.master       csr_o,
    output logic              stall_o,
    output logic              flush_o,
    output logic              redirect_o,
    output logic [DW-1:0]     pc_o,
    output logic              busy_o
);

    typedef enum logic [2:0] {
        IDLE, WAIT_BND, W_EPC, W_CAUSE, W_STAT, REDIR, MRET_ST, MRET_RD
    } state_e;

    state_e        state_q, state_d;
    logic          is_ext_q, is_ext_d;
    logic [DW-1:0] pc_q, pc_d;

    logic          ext_ok, tim_ok, take;
    logic [DW-1:0] cause_val, vec_base, trap_target;
    logic          unused_bits;

    // Trap entry: MPIE takes the old MIE, MIE is cleared so no nested trap is taken.
    function automatic logic [DW-1:0] trap_mstatus(input logic [DW-1:0] s);
        logic [DW-1:0] r;
        r    = s;
        r[7] = s[3];
        r[3] = 1'b0;
        return r;
    endfunction

    function automatic logic [DW-1:0] mret_mstatus(input logic [DW-1:0] s);
        logic [DW-1:0] r;
        r    = s;
        r[3] = s[7];
        r[7] = 1'b1;
        return r;
    endfunction

    assign ext_ok = e_intr_i & mie_i[11] & mstatus_i[3];
    assign tim_ok = t_intr_i & mie_i[7]  & mstatus_i[3];
    assign take   = ext_ok | tim_ok;

    assign cause_val   = is_ext_q ? DW'(MEI_CAUSE) : DW'(MTI_CAUSE);
    assign vec_base    = {mtvec_i[DW-1:2], 2'b00};
    assign trap_target = (mtvec_i[1:0] == 2'b01) ? vec_base + (cause_val << 2) : vec_base;

    assign unused_bits = ^{mie_i, cause_val[DW-1]};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath holding registers carry no reset; they are only read after being loaded.
    always_ff @(posedge clk_i) begin
        pc_q     <= pc_d;
        is_ext_q <= is_ext_d;
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        is_ext_d    = is_ext_q;
        csr_o.we    = 1'b0;
        csr_o.addr  = '0;
        csr_o.wdata = '0;
        stall_o     = 1'b0;
        flush_o     = 1'b0;
        redirect_o  = 1'b0;
        pc_o        = '0;
        busy_o      = (state_q != IDLE);

        unique case (state_q)
            IDLE: begin
                if (is_mret_i) begin
                    state_d = MRET_ST;
                end else if (take) begin
                    is_ext_d = ext_ok;
                    state_d  = WAIT_BND;
                end
            end
            WAIT_BND: begin
                stall_o = 1'b1;
                if (commit_valid_i) begin
                    pc_d    = commit_pc_i;
                    state_d = W_EPC;
                end
            end
            W_EPC: begin
                stall_o     = 1'b1;
                csr_o.we    = 1'b1;
                csr_o.addr  = ADDRW'(12'h341);
                csr_o.wdata = pc_q;
                state_d     = W_CAUSE;
            end
            W_CAUSE: begin
                stall_o     = 1'b1;
                csr_o.we    = 1'b1;
                csr_o.addr  = ADDRW'(12'h342);
                csr_o.wdata = {1'b1, cause_val[DW-2:0]};
                state_d     = W_STAT;
            end
            W_STAT: begin
                stall_o     = 1'b1;
                csr_o.we    = 1'b1;
                csr_o.addr  = ADDRW'(12'h300);
                csr_o.wdata = trap_mstatus(mstatus_i);
                state_d     = REDIR;
            end
            REDIR: begin
                redirect_o = 1'b1;
                flush_o    = 1'b1;
                pc_o       = trap_target;
                state_d    = IDLE;
            end
            MRET_ST: begin
                stall_o     = 1'b1;
                csr_o.we    = 1'b1;
                csr_o.addr  = ADDRW'(12'h300);
                csr_o.wdata = mret_mstatus(mstatus_i);
                state_d     = MRET_RD;
            end
            MRET_RD: begin
                redirect_o = 1'b1;
                flush_o    = 1'b1;
                pc_o       = mepc_i;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
